// File: rtl/control_outs_pkg.sv
// ----------------------------------------------------------------------------
// Module  : control_outs_pkg
// Purpose : Shared definitions for the host-link framing logic: instruction
//           opcodes (bits [7:5] of the first frame byte), activemods bit
//           positions, framer state encodings and a header-byte helper.
//           The command decoder uses the same opcode values.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

package control_outs_pkg;

  // Instruction opcodes, bits [7:5] of a frame's first byte
  localparam logic [2:0] ACTIVATE_I      = 3'b001;
  localparam logic [2:0] SETDIGITAL_I    = 3'b010;
  localparam logic [2:0] SETANALOG_I     = 3'b011;
  localparam logic [2:0] SAMPLEANALOG_I  = 3'b100;
  localparam logic [2:0] SAMPLEDIGITAL_I = 3'b101;

  // activemods bit positions
  localparam int MOD_ADC0 = 0;
  localparam int MOD_ADC1 = 1;
  localparam int MOD_ADC2 = 2;
  localparam int MOD_ADC3 = 3;
  localparam int MOD_DIN  = 4;
  localparam int NUM_MODS = 5;

  // Framer state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEL  = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;

  // Header byte: {op[2:0], ch[1:0], seq[1:0], ovr}
  function automatic logic [7:0] make_hdr(input logic [2:0] op, input logic [1:0] ch,
                                          input logic [1:0] seq, input logic ovr);
    return {op, ch, seq, ovr};
  endfunction

endpackage

`default_nettype wire

// File: rtl/control_prio_enc.sv
// ----------------------------------------------------------------------------
// Module  : control_prio_enc
// Purpose : 5-bit lowest-set-bit priority encoder.
// Ports   : req   in  5  request vector (bit 0 has highest priority)
//           idx   out 3  index of lowest set bit (0 when none set)
//           valid out 1  at least one request bit set
// Rev     : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

module control_prio_enc
  import control_outs_pkg::*;
(
  input  logic [NUM_MODS-1:0] req,
  output logic [2:0]          idx,
  output logic                valid
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx   = 3'd0;
    valid = |req;
    for (int i = NUM_MODS - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = 3'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/control_outs.sv
// ----------------------------------------------------------------------------
// Module  : control_outs
// Purpose : TX-side framer for the host link. On sample_tick it snapshots the
//           enabled sources and pushes one tagged frame per source into the
//           TX byte queue (ADC0..ADC3 first, digital input last).
// Ports   : clk, rst           clock, synchronous active-high reset
//           sample_tick  in  1  snapshot request strobe
//           activemods   in  5  source enables ([3:0] ADC, [4] digital)
//           adc0..adc3   in 12  ADC samples
//           din          in  8  digital input port
//           fu_write     in  1  TX queue full
//           pu_write     out 1  push strobe
//           out_write    out 8  byte to push
//           busy         out 1  snapshot being emitted
//           overrun_cnt  out 8  saturating count of dropped ticks
// Rev     : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

module control_outs
  import control_outs_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_tick,
  input  logic [4:0]  activemods,
  input  logic [11:0] adc0,
  input  logic [11:0] adc1,
  input  logic [11:0] adc2,
  input  logic [11:0] adc3,
  input  logic [7:0]  din,
  input  logic        fu_write,
  output logic        pu_write,
  output logic [7:0]  out_write,
  output logic        busy,
  output logic [7:0]  overrun_cnt
);

  localparam logic [2:0] DIN_IDX = 3'(MOD_DIN);

  logic [1:0]  r_state;
  logic [1:0]  w_next_state;
  logic [4:0]  r_pending;
  logic [11:0] r_adc [4];
  logic [7:0]  r_din;
  logic [1:0]  r_seq;        // seq for the next accepted snapshot
  logic [1:0]  r_snap_seq;   // seq of the snapshot in flight
  logic        r_ovr_pend;   // a tick was dropped since the last accept
  logic        r_snap_ovr;
  logic [1:0]  r_byte_idx;
  logic [2:0]  r_cur;
  logic [7:0]  r_overrun_cnt;

  logic [2:0]  w_sel_idx;
  logic        w_sel_valid;
  logic        w_accept;
  logic        w_drop;
  logic        w_push;
  logic        w_is_din;
  logic        w_last;
  logic [11:0] w_adc;
  logic [7:0]  w_hdr;

  control_prio_enc u_prio (
    .req   (r_pending),
    .idx   (w_sel_idx),
    .valid (w_sel_valid)
  );

  // Any tick outside IDLE is dropped, including the final-push cycle and the
  // trailing SEL cycle.
  assign w_accept = (r_state == ST_IDLE) && sample_tick && (activemods != 5'd0);
  assign w_drop   = (r_state != ST_IDLE) && sample_tick;
  assign w_push   = (r_state == ST_SEND) && !fu_write;
  assign w_is_din = (r_cur == DIN_IDX);
  assign w_last   = w_is_din ? (r_byte_idx == 2'd1) : (r_byte_idx == 2'd2);
  assign w_adc    = r_adc[r_cur[1:0]];
  assign w_hdr    = make_hdr(w_is_din ? SAMPLEDIGITAL_I : SAMPLEANALOG_I,
                             w_is_din ? 2'b00 : r_cur[1:0], r_snap_seq, r_snap_ovr);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next_state = ST_SEL;
      ST_SEL:  w_next_state = w_sel_valid ? ST_SEND : ST_IDLE;
      ST_SEND: if (w_push && w_last) w_next_state = ST_SEL;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Snapshot and frame datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending     <= 5'd0;
      for (int i = 0; i < 4; i++) r_adc[i] <= 12'd0;
      r_din         <= 8'd0;
      r_seq         <= 2'd0;
      r_snap_seq    <= 2'd0;
      r_ovr_pend    <= 1'b0;
      r_snap_ovr    <= 1'b0;
      r_byte_idx    <= 2'd0;
      r_cur         <= 3'd0;
      r_overrun_cnt <= 8'd0;
    end else begin
      if (w_accept) begin
        r_pending  <= activemods;
        r_adc[0]   <= adc0;
        r_adc[1]   <= adc1;
        r_adc[2]   <= adc2;
        r_adc[3]   <= adc3;
        r_din      <= din;
        r_snap_seq <= r_seq;
        r_seq      <= r_seq + 2'd1;
        r_snap_ovr <= r_ovr_pend;
        r_ovr_pend <= 1'b0;
      end
      if (w_drop) begin
        r_ovr_pend <= 1'b1;
        if (r_overrun_cnt != 8'hFF) r_overrun_cnt <= r_overrun_cnt + 8'd1;
      end
      if (r_state == ST_SEL) begin
        r_cur      <= w_sel_idx;
        r_byte_idx <= 2'd0;
      end
      if (w_push) begin
        if (w_last) begin
          r_pending <= r_pending & ~(5'b00001 << r_cur);
        end else begin
          r_byte_idx <= r_byte_idx + 2'd1;
        end
      end
    end
  end

  // Outputs: out_write depends only on registers, so it holds during stalls.
  always_comb begin
    pu_write    = 1'b0;
    out_write   = 8'h00;
    busy        = (r_state != ST_IDLE);
    overrun_cnt = r_overrun_cnt;
    if (r_state == ST_SEND) begin
      pu_write = !fu_write;
      case (r_byte_idx)
        2'd0:    out_write = w_hdr;
        2'd1:    out_write = w_is_din ? r_din : {4'h0, w_adc[11:8]};
        default: out_write = w_adc[7:0];
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_control_outs.sv
// ----------------------------------------------------------------------------
// Module  : tb_control_outs
// Purpose : Self-checking bench for control_outs. Expected bytes are queued
//           when a snapshot is requested and compared as the DUT pushes them.
// Rev     : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_control_outs;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_tick = 1'b0;
  logic [4:0]  activemods = 5'd0;
  logic [11:0] adc0 = 12'd0, adc1 = 12'd0, adc2 = 12'd0, adc3 = 12'd0;
  logic [7:0]  din = 8'd0;
  logic        fu_write = 1'b0;
  logic        pu_write;
  logic [7:0]  out_write;
  logic        busy;
  logic [7:0]  overrun_cnt;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  logic [1:0] m_seq;
  logic       m_ovr;
  int         m_cnt;

  typedef struct {
    logic [4:0]  mask;
    logic [11:0] a0, a1, a2, a3;
    logic [7:0]  d;
    logic [7:0]  exp_hdr0;
  } vec_t;

  vec_t tbl[6];

  control_outs dut (
    .clk         (clk),
    .rst         (rst),
    .sample_tick (sample_tick),
    .activemods  (activemods),
    .adc0        (adc0),
    .adc1        (adc1),
    .adc2        (adc2),
    .adc3        (adc3),
    .din         (din),
    .fu_write    (fu_write),
    .pu_write    (pu_write),
    .out_write   (out_write),
    .busy        (busy),
    .overrun_cnt (overrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every push must match the head of the queue.
  always @(negedge clk) begin
    if (pu_write) begin
      check("no_push_while_full", {31'd0, fu_write}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_push: got %0h expected none", out_write);
      end else begin
        mon_exp = exp_q.pop_front();
        check("byte", {24'd0, out_write}, {24'd0, mon_exp});
      end
    end
  end

  task automatic model_snapshot(input logic [4:0] m, input logic [11:0] a0, input logic [11:0] a1,
                                input logic [11:0] a2, input logic [11:0] a3, input logic [7:0] d);
    logic [11:0] a [4];
    if (m == 5'd0) return;
    a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3;
    for (int ch = 0; ch < 4; ch++) begin
      if (m[ch]) begin
        exp_q.push_back({3'b100, 2'(ch), m_seq, m_ovr});
        exp_q.push_back({4'h0, a[ch][11:8]});
        exp_q.push_back(a[ch][7:0]);
      end
    end
    if (m[4]) begin
      exp_q.push_back({3'b101, 2'b00, m_seq, m_ovr});
      exp_q.push_back(d);
    end
    m_seq = m_seq + 2'd1;
    m_ovr = 1'b0;
  endtask

  task automatic model_drop();
    m_ovr = 1'b1;
    if (m_cnt < 255) m_cnt++;
  endtask

  task automatic set_inputs(input logic [11:0] a0, input logic [11:0] a1, input logic [11:0] a2,
                            input logic [11:0] a3, input logic [7:0] d);
    adc0 = a0; adc1 = a1; adc2 = a2; adc3 = a3; din = d;
  endtask

  // Called and returns at posedge+1; the tick is sampled at the next edge.
  task automatic pulse(input logic [4:0] m);
    sample_tick = 1'b1;
    activemods  = m;
    @(posedge clk); #1;
    sample_tick = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1; sample_tick = 1'b0; fu_write = 1'b0; activemods = 5'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    m_seq = 2'd0; m_ovr = 1'b0; m_cnt = 0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    @(posedge clk); #1;
    while (busy && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_idle"}, {31'd0, busy}, 32'd0);
    check({name, "_drained"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    apply_reset();
    check("rst_pu_write", {31'd0, pu_write}, 32'd0);
    check("rst_out_write", {24'd0, out_write}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_overrun", {24'd0, overrun_cnt}, 32'd0);

    // Single ADC frame with latency checks
    set_inputs(12'hABC, 12'h111, 12'h222, 12'h333, 8'h44);
    exp_q.push_back(8'h80); exp_q.push_back(8'h0A); exp_q.push_back(8'hBC);
    pulse(5'b00001);
    check("sel_busy", {31'd0, busy}, 32'd1);
    check("sel_no_push", {31'd0, pu_write}, 32'd0);
    @(posedge clk); #1;
    check("first_hdr_push", {31'd0, pu_write}, 32'd1);
    wait_idle("single", 20);

    // Mixed snapshot from a fresh seq
    apply_reset();
    set_inputs(12'h000, 12'h000, 12'h123, 12'hFFF, 8'h5A);
    exp_q.push_back(8'h90); exp_q.push_back(8'h01); exp_q.push_back(8'h23);
    exp_q.push_back(8'hA0); exp_q.push_back(8'h5A);
    pulse(5'b10100);
    set_inputs(12'h777, 12'h777, 12'h777, 12'h777, 8'h77);
    wait_idle("mixed", 30);

    // Table-driven snapshots: seq 0,1,(mask0),2,3,0
    tbl[0] = '{5'b11111, 12'(($urandom_range(0, 4095))), 12'(($urandom_range(0, 4095))),
               12'(($urandom_range(0, 4095))), 12'(($urandom_range(0, 4095))), 8'(($urandom_range(0, 255))), 8'h80};
    tbl[1] = '{5'b01010, 12'h1F0, 12'hE01, 12'h5A5, 12'h0C3, 8'h3C, 8'h8A};
    tbl[2] = '{5'b00000, 12'h999, 12'h999, 12'h999, 12'h999, 8'h99, 8'h00};
    tbl[3] = '{5'b10000, 12'h000, 12'h000, 12'h000, 12'h000, 8'hC7, 8'hA4};
    tbl[4] = '{5'b00110, 12'h000, 12'h8F1, 12'h07E, 12'h000, 8'h00, 8'h8E};
    tbl[5] = '{5'b01000, 12'h000, 12'h000, 12'h000, 12'hD42, 8'h00, 8'h98};
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      set_inputs(tbl[i].a0, tbl[i].a1, tbl[i].a2, tbl[i].a3, tbl[i].d);
      model_snapshot(tbl[i].mask, tbl[i].a0, tbl[i].a1, tbl[i].a2, tbl[i].a3, tbl[i].d);
      pulse(tbl[i].mask);
      set_inputs(12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom), 8'($urandom));
      if (tbl[i].mask == 5'd0) begin
        check("mask0_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(posedge clk);
        #1 check("mask0_no_push", exp_q.size(), 32'd0);
      end else begin
        int n = 0;
        while (!pu_write && n < 10) begin
          @(negedge clk);
          n++;
        end
        check("tbl_hdr0", {24'd0, out_write}, {24'd0, tbl[i].exp_hdr0});
        wait_idle("tbl", 40);
      end
    end

    // Backpressure: stall four cycles on the second byte
    apply_reset();
    set_inputs(12'hABC, 12'h0, 12'h0, 12'h0, 8'h0);
    model_snapshot(5'b00001, 12'hABC, 12'h0, 12'h0, 12'h0, 8'h0);
    pulse(5'b00001);
    @(posedge clk); #1;
    @(posedge clk); #1;
    fu_write = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("stall_no_push", {31'd0, pu_write}, 32'd0);
      check("stall_hold", {24'd0, out_write}, 32'h0A);
      @(posedge clk); #1;
    end
    fu_write = 1'b0;
    wait_idle("bp", 20);

    // Overrun flag, seq progression and counter saturation
    apply_reset();
    set_inputs(12'h321, 12'h654, 12'h987, 12'hCBA, 8'hE5);
    model_snapshot(5'b00001, 12'h321, 12'h654, 12'h987, 12'hCBA, 8'hE5);
    pulse(5'b00001);
    pulse(5'b00001);
    model_drop();
    check("overrun_one", {24'd0, overrun_cnt}, 32'd1);
    wait_idle("ovr_a", 20);
    model_snapshot(5'b00011, 12'h321, 12'h654, 12'h987, 12'hCBA, 8'hE5);
    pulse(5'b00011);
    wait_idle("ovr_b", 30);
    model_snapshot(5'b00001, 12'h321, 12'h654, 12'h987, 12'hCBA, 8'hE5);
    pulse(5'b00001);
    wait_idle("ovr_c", 20);
    model_snapshot(5'b10001, 12'h321, 12'h654, 12'h987, 12'hCBA, 8'hE5);
    pulse(5'b10001);
    fu_write = 1'b1;
    for (int i = 0; i < 260; i++) begin
      pulse(5'b00001);
      model_drop();
      if (i == 199) check("overrun_mid", {24'd0, overrun_cnt}, m_cnt);
    end
    check("overrun_sat", {24'd0, overrun_cnt}, 32'd255);
    fu_write = 1'b0;
    wait_idle("ovr_d", 30);

    // Reset mid-frame, then a fresh snapshot starts over at seq 0
    exp_q.push_back({3'b100, 2'b00, m_seq, m_ovr});
    pulse(5'b00001);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstmid_pu_write", {31'd0, pu_write}, 32'd0);
    check("rstmid_out_write", {24'd0, out_write}, 32'd0);
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    check("rstmid_overrun", {24'd0, overrun_cnt}, 32'd0);
    check("rstmid_hdr_seen", exp_q.size(), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back(8'h80); exp_q.push_back(8'h03); exp_q.push_back(8'h21);
    pulse(5'b00001);
    wait_idle("restart", 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
